// File: rtl/rgb_timebase.sv
// Free-running WIDTH-bit timebase. It emits NTAPS nested one-cycle strobes; tap i follows
// counter bit TAP_BIT(i) = (i*(WIDTH-1))/(NTAPS-1). The wrap strobe marks the all-ones -> 0 rollover.
module rgb_timebase #(
  parameter int WIDTH = 27,
  parameter int NTAPS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             clear,
  output logic [NTAPS-1:0] taps,
  output logic             wrap,
  output logic [WIDTH-1:0] count
);

  if (NTAPS < 2 || NTAPS > WIDTH) begin : g_bad_params
    $error("rgb_timebase: NTAPS must be in [2, WIDTH]");
  end

  // Downstream dividers use this same formula, so the tap spacing must not change.
  function automatic int tap_bit(input int i);
    return (NTAPS > 1) ? (i * (WIDTH - 1)) / (NTAPS - 1) : 0;
  endfunction

  logic             adv;
  logic [NTAPS-1:0] tap_hit;

  assign adv = run | step;

  // Tap i strobes on the edge that carries out of bit tap_bit(i).
  for (genvar g = 0; g < NTAPS; g++) begin : g_tap
    localparam int B = tap_bit(g);
    assign tap_hit[g] = &count[B:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      taps  <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      taps  <= '0;
      wrap  <= 1'b0;
    end else if (adv) begin
      count <= count + WIDTH'(1);
      taps  <= tap_hit;
      wrap  <= &count;
    end else begin
      taps  <= '0;
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rgb_timebase.sv
// Directed bench for rgb_timebase with WIDTH=8 and NTAPS=3, so the taps follow counter bits 0, 3 and 7.
// A per-cycle reference model feeds an expected queue, and targeted checks cover the listed scenarios.
module tb_rgb_timebase;

  localparam int WIDTH = 8;
  localparam int NTAPS = 3;
  localparam int W     = WIDTH + NTAPS + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             step = 1'b0;
  logic             clear = 1'b0;
  logic [NTAPS-1:0] taps;
  logic             wrap;
  logic [WIDTH-1:0] count;

  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           m_cnt = 0;
  int           tb_bits[NTAPS] = '{0, 3, 7};

  rgb_timebase #(.WIDTH(WIDTH), .NTAPS(NTAPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .step  (step),
    .clear (clear),
    .taps  (taps),
    .wrap  (wrap),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drives one clock of stimulus, queues the model's prediction, and checks the DUT after the edge.
  task automatic tick(input logic r, input logic s, input logic c, input logic rn);
    logic [NTAPS-1:0] e_taps;
    logic             e_wrap;
    logic [W-1:0]     e;
    logic [W-1:0]     o;
    run = r; step = s; clear = c; rst_n = rn;
    e_taps = '0;
    e_wrap = 1'b0;
    if (!rn || c) begin
      m_cnt = 0;
    end else if (r || s) begin
      for (int i = 0; i < NTAPS; i++) begin
        int p;
        p = 1 << (tb_bits[i] + 1);
        e_taps[i] = ((m_cnt % p) == p - 1);
      end
      e_wrap = (m_cnt == 255);
      m_cnt = (m_cnt + 1) % 256;
    end
    exp_q.push_back({8'(m_cnt), e_taps, e_wrap});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {count, taps, wrap};
    cyc++;
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL sb cyc=%0d observed=%h expected=%h", cyc, o, e);
    end
  endtask

  initial begin
    int t0_first, t1_first, t2_first, w_first, n, t0n, t1n, any_tap;

    // Reset
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_count", int'(count), 0);
    chk("reset_taps", int'(taps), 0);
    chk("reset_wrap", int'(wrap), 0);

    // 1: first strobe timing after release
    t0_first = 0; t1_first = 0; t2_first = 0; w_first = 0;
    for (int k = 1; k <= 256; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      if (taps[0] && t0_first == 0) t0_first = k;
      if (taps[1] && t1_first == 0) t1_first = k;
      if (taps[2] && t2_first == 0) t2_first = k;
      if (wrap && w_first == 0) w_first = k;
    end
    chk("t1_tap0_first", t0_first, 2);
    chk("t1_tap1_first", t1_first, 16);
    chk("t1_tap2_first", t2_first, 256);
    chk("t1_wrap_first", w_first, 256);

    // 2: rollover from 255
    repeat (255) tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_count255", int'(count), 255);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_wrap_taps", int'(taps), 7);
    chk("t2_wrap", int'(wrap), 1);
    chk("t2_wrap_count", int'(count), 0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_after_taps", int'(taps), 0);
    chk("t2_after_wrap", int'(wrap), 0);

    // 3: freeze at 37, then resume
    repeat (36) tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3_count37", int'(count), 37);
    any_tap = 0;
    repeat (50) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      if (taps != 0 || count != 8'd37) any_tap = 1;
    end
    chk("t3_frozen", any_tap, 0);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      if (taps[1]) begin n = k; break; end
    end
    chk("t3_resume_tap1", n, 11);

    // 4: single-step from zero
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4_clear_count", int'(count), 0);
    t0n = 0; t1n = 0;
    for (int k = 1; k <= 15; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      t0n += int'(taps[0]);
      t1n += int'(taps[1]);
    end
    chk("t4_count15", int'(count), 15);
    chk("t4_tap0_n", t0n, 7);
    chk("t4_tap1_n", t1n, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("t4_step16_tap1", int'(taps[1]), 1);
    // run and step together must not double-count
    repeat (10) tick(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t4_no_double", int'(count), 26);

    // 5: clear together with run at 127
    repeat (101) tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_count127", int'(count), 127);
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_clear_count", int'(count), 0);
    chk("t5_clear_taps", int'(taps), 0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_plus1_tap0", int'(taps[0]), 0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_plus2_tap0", int'(taps[0]), 1);

    // 6: reset mid-period at 200
    repeat ($urandom_range(0, 0) + 198) tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_count200", int'(count), 200);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_taps", int'(taps), 0);
    chk("t6_rst_wrap", int'(wrap), 0);
    t0_first = 0; t1_first = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      if (taps[0] && t0_first == 0) t0_first = k;
      if (taps[1] && t1_first == 0) t1_first = k;
    end
    chk("t6_tap0_first", t0_first, 2);
    chk("t6_tap1_first", t1_first, 16);

    // Random run/step mix, checked by the model only
    repeat (300) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 40) == 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
